// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR2 command scheduler: pin encodings, FSM states,
// address field positions and default timing.
package ddr_pkg;

    // {CS_, RAS_, CAS_, WE_}
    localparam logic [3:0] CmdDesel = 4'b1111;
    localparam logic [3:0] CmdNop   = 4'b0111;
    localparam logic [3:0] CmdAct   = 4'b0011;
    localparam logic [3:0] CmdRd    = 4'b0101;
    localparam logic [3:0] CmdWr    = 4'b0100;
    localparam logic [3:0] CmdRef   = 4'b0001;

    typedef enum logic [2:0] {
        StIdle,
        StAct,
        StTrcd,
        StRw,
        StTpre,
        StRef,
        StTrfc
    } ddr_state_e;

    localparam int unsigned ColLsb  = 0;
    localparam int unsigned ColMsb  = 9;
    localparam int unsigned BankLsb = 10;
    localparam int unsigned BankMsb = 12;
    localparam int unsigned RowLsb  = 13;
    localparam int unsigned RowMsb  = 26;

    localparam int unsigned DefTRcd  = 3;
    localparam int unsigned DefTRp   = 4;
    localparam int unsigned DefTRfc  = 26;
    localparam int unsigned DefTRefi = 1560;

endpackage

// File: rtl/ddr_refresh_timer.sv
// Free-running refresh interval counter; raises ref_pend at each wrap and holds it
// until the scheduler acknowledges with ref_ack. At most one refresh is ever owed.
module ddr_refresh_timer #(
    parameter int unsigned T_REFI = 1560
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ref_ack,
    output logic ref_pend
);

    localparam int unsigned   CntW    = $clog2(T_REFI);
    localparam logic [CntW-1:0] CntLast = CntW'(T_REFI - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic            wrap;

    always_comb begin
        wrap   = (cnt_q == CntLast);
        cnt_d  = wrap ? '0 : cnt_q + CntW'(1);
        pend_d = pend_q;
        if (ref_ack) begin
            pend_d = 1'b0;
        end
        if (wrap) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign ref_pend = pend_q;

endmodule

// File: rtl/ddr_cmd_sched.sv
// Closed-page DDR2 command scheduler: round-robin read/write arbitration, ACT then
// RD/WR with auto-precharge, periodic refresh. DDR_SCHED_WR_PRIO_EN makes write win ties.
module ddr_cmd_sched
    import ddr_pkg::*;
#(
    parameter int unsigned T_RCD  = DefTRcd,
    parameter int unsigned T_RP   = DefTRp,
    parameter int unsigned T_RFC  = DefTRfc,
    parameter int unsigned T_REFI = DefTRefi
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    output logic        rd_gnt,
    input  logic        wr_req,
    input  logic [31:0] wr_addr,
    output logic        wr_gnt,
    output logic        CKE,
    output logic        CS_,
    output logic        RAS_,
    output logic        CAS_,
    output logic        WE_,
    output logic [2:0]  AB,
    output logic [13:0] A,
    output logic        busy
);

    // Each wait state exits when its counter reaches the value below.
    localparam logic [7:0] TrcdLast = 8'(T_RCD - 2);
    localparam logic [7:0] TpreLast = 8'(T_RP - 1);
    localparam logic [7:0] TrfcLast = 8'(T_RFC - 2);

    ddr_state_e  st_q, st_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [26:0] addr_q, addr_d;
    logic        dir_wr_q, dir_wr_d;
    logic        last_wr_q, last_wr_d;

    logic        cke_q;
    logic [3:0]  cmd_q, cmd_d;
    logic [2:0]  ab_q, ab_d;
    logic [13:0] a_q, a_d;
    logic        rd_gnt_q, rd_gnt_d;
    logic        wr_gnt_q, wr_gnt_d;
    logic        busy_q;

    logic        ref_pend;
    logic        ref_ack;
    logic        pick_wr;
    logic        unused_addr;

    assign unused_addr = ^{rd_addr[31:27], wr_addr[31:27]};

`ifdef DDR_SCHED_WR_PRIO_EN
    assign pick_wr = wr_req;
`else
    assign pick_wr = wr_req && (!rd_req || !last_wr_q);
`endif

    ddr_refresh_timer #(
        .T_REFI (T_REFI)
    ) u_refresh_timer (
        .clk_i    (ACLK),
        .rst_ni   (ARESETN),
        .ref_ack  (ref_ack),
        .ref_pend (ref_pend)
    );

    always_comb begin
        st_d      = st_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        dir_wr_d  = dir_wr_q;
        last_wr_d = last_wr_q;
        ref_ack   = 1'b0;
        case (st_q)
            StIdle: begin
                // Nothing issues until CKE has been high for a cycle.
                if (cke_q) begin
                    if (ref_pend) begin
                        ref_ack = 1'b1;
                        st_d    = StRef;
                    end else if (rd_req || wr_req) begin
                        addr_d    = pick_wr ? wr_addr[26:0] : rd_addr[26:0];
                        dir_wr_d  = pick_wr;
                        last_wr_d = pick_wr;
                        st_d      = StAct;
                    end
                end
            end
            StAct: begin
                cnt_d = '0;
                st_d  = (T_RCD > 1) ? StTrcd : StRw;
            end
            StTrcd: begin
                if (cnt_q == TrcdLast) begin
                    st_d = StRw;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StRw: begin
                cnt_d = '0;
                st_d  = StTpre;
            end
            StTpre: begin
                if (cnt_q == TpreLast) begin
                    st_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StRef: begin
                cnt_d = '0;
                st_d  = (T_RFC > 1) ? StTrfc : StIdle;
            end
            StTrfc: begin
                if (cnt_q == TrfcLast) begin
                    st_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: st_d = StIdle;
        endcase
    end

    // Pins are decoded from the next state so they line up with the state register.
    always_comb begin
        cmd_d    = CmdDesel;
        ab_d     = '0;
        a_d      = '0;
        rd_gnt_d = 1'b0;
        wr_gnt_d = 1'b0;
        case (st_d)
            StAct: begin
                cmd_d = CmdAct;
                ab_d  = addr_d[BankMsb:BankLsb];
                a_d   = addr_d[RowMsb:RowLsb];
            end
            StRw: begin
                cmd_d    = dir_wr_d ? CmdWr : CmdRd;
                ab_d     = addr_d[BankMsb:BankLsb];
                a_d      = {3'b000, 1'b1, addr_d[ColMsb:ColLsb]};
                rd_gnt_d = !dir_wr_d;
                wr_gnt_d = dir_wr_d;
            end
            StRef:                  cmd_d = CmdRef;
            StTrcd, StTpre, StTrfc: cmd_d = CmdNop;
            default:                cmd_d = CmdDesel;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            st_q      <= StIdle;
            cnt_q     <= '0;
            addr_q    <= '0;
            dir_wr_q  <= 1'b0;
            last_wr_q <= 1'b1;
            cke_q     <= 1'b0;
            cmd_q     <= CmdDesel;
            ab_q      <= '0;
            a_q       <= '0;
            rd_gnt_q  <= 1'b0;
            wr_gnt_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            st_q      <= st_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            dir_wr_q  <= dir_wr_d;
            last_wr_q <= last_wr_d;
            cke_q     <= 1'b1;
            cmd_q     <= cmd_d;
            ab_q      <= ab_d;
            a_q       <= a_d;
            rd_gnt_q  <= rd_gnt_d;
            wr_gnt_q  <= wr_gnt_d;
            busy_q    <= (st_d != StIdle);
        end
    end

    assign CKE                 = cke_q;
    assign {CS_, RAS_, CAS_, WE_} = cmd_q;
    assign AB                  = ab_q;
    assign A                   = a_q;
    assign rd_gnt              = rd_gnt_q;
    assign wr_gnt              = wr_gnt_q;
    assign busy                = busy_q;

endmodule

// File: tb/tb_ddr_cmd_sched.sv
// Directed bench for ddr_cmd_sched: expected commands are queued as stimulus is driven
// and checked by a pin monitor as the DUT issues them.
module tb_ddr_cmd_sched;

    localparam int T_RCD  = 3;
    localparam int T_RP   = 4;
    localparam int T_RFC  = 26;
    localparam int T_REFI = 100;

    localparam logic [3:0] P_DESEL = 4'b1111;
    localparam logic [3:0] P_NOP   = 4'b0111;
    localparam logic [3:0] P_ACT   = 4'b0011;
    localparam logic [3:0] P_RD    = 4'b0101;
    localparam logic [3:0] P_WR    = 4'b0100;
    localparam logic [3:0] P_REF   = 4'b0001;

`ifdef DDR_SCHED_WR_PRIO_EN
    localparam bit WrPrio = 1'b1;
`else
    localparam bit WrPrio = 1'b0;
`endif

    logic        ACLK;
    logic        ARESETN;
    logic        rd_req, wr_req;
    logic [31:0] rd_addr, wr_addr;
    logic        rd_gnt, wr_gnt;
    logic        CKE, CS_, RAS_, CAS_, WE_;
    logic [2:0]  AB;
    logic [13:0] A;
    logic        busy;

    typedef struct {
        int         cyc;
        logic [3:0] cmd;
        logic [2:0] ab;
        logic [13:0] a;
        logic [1:0] gnt;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    logic [3:0] pins;
    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    ddr_cmd_sched #(
        .T_RCD  (T_RCD),
        .T_RP   (T_RP),
        .T_RFC  (T_RFC),
        .T_REFI (T_REFI)
    ) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .rd_req  (rd_req),
        .rd_addr (rd_addr),
        .rd_gnt  (rd_gnt),
        .wr_req  (wr_req),
        .wr_addr (wr_addr),
        .wr_gnt  (wr_gnt),
        .CKE     (CKE),
        .CS_     (CS_),
        .RAS_    (RAS_),
        .CAS_    (CAS_),
        .WE_     (WE_),
        .AB      (AB),
        .A       (A),
        .busy    (busy)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic step_to(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic do_reset();
        step(1);
        ARESETN = 1'b0;
        step(3);
        ARESETN = 1'b1;
    endtask

    task automatic push(input int c, input logic [3:0] cmd, input logic [2:0] ab,
                        input logic [13:0] a, input logic [1:0] gnt);
        exp_t x;
        x.cyc = c; x.cmd = cmd; x.ab = ab; x.a = a; x.gnt = gnt;
        sb.push_back(x);
    endtask

    // p is the cycle the request is first seen in IDLE.
    task automatic expect_act(input int p, input logic [31:0] addr);
        push(p + 1, P_ACT, addr[12:10], addr[26:13], 2'b00);
    endtask

    task automatic expect_rw(input int p, input bit wr, input logic [31:0] addr);
        push(p + 1 + T_RCD, wr ? P_WR : P_RD, addr[12:10], {3'b000, 1'b1, addr[9:0]},
             wr ? 2'b01 : 2'b10);
    endtask

    task automatic wait_gnt(input int limit, output int at, output logic [1:0] which);
        at = -1;
        which = 2'b00;
        for (int i = 0; i < limit; i++) begin
            step(1);
            if (rd_gnt || wr_gnt) begin
                at = cyc;
                which = {rd_gnt, wr_gnt};
                break;
            end
        end
        n_cmp++;
        assert (at >= 0) else begin
            n_err++;
            $error("FAIL gnt_timeout: observed none expected gnt within %0d cycles", limit);
        end
    endtask

    always @(negedge ACLK) begin
        if (ARESETN) begin
            pins = {CS_, RAS_, CAS_, WE_};
            if (pins != P_NOP && pins != P_DESEL) begin
                if (sb.size() == 0) begin
                    chk("unexpected_cmd", {28'd0, pins}, {28'd0, P_DESEL});
                end else begin
                    e = sb.pop_front();
                    chk("cmd_cycle", cyc, e.cyc);
                    chk("cmd_pins", {28'd0, pins}, {28'd0, e.cmd});
                    chk("cmd_ab", {29'd0, AB}, {29'd0, e.ab});
                    chk("cmd_a", {18'd0, A}, {18'd0, e.a});
                    chk("cmd_gnt", {30'd0, rd_gnt, wr_gnt}, {30'd0, e.gnt});
                end
            end else begin
                chk("gnt_without_cmd", {30'd0, rd_gnt, wr_gnt}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed cycle %0d expected completion", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int p, g, q, r;
        logic [1:0] which;
        bit wr_k;

        ARESETN = 1'b0;
        rd_req = 1'b0; wr_req = 1'b0;
        rd_addr = '0;  wr_addr = '0;

        // Reset state and CKE release.
        step(3);
        chk("rst_cke", CKE, 0);
        chk("rst_pins", {CS_, RAS_, CAS_, WE_}, P_DESEL);
        chk("rst_ab_a", {AB, A}, 0);
        chk("rst_gnt_busy", {rd_gnt, wr_gnt, busy}, 0);
        ARESETN = 1'b1;
        chk("cke_before_edge", CKE, 0);
        step(1);
        chk("cke_rise", CKE, 1);
        chk("no_cmd_at_cke", ({CS_, RAS_, CAS_, WE_} == P_DESEL) ||
                             ({CS_, RAS_, CAS_, WE_} == P_NOP), 1);

        // Single read.
        p = cyc;
        rd_addr = 32'h0012_3456;
        rd_req = 1'b1;
        push(p + 1, P_ACT, 3'd5, 14'h091, 2'b00);
        push(p + 1 + T_RCD, P_RD, 3'd5, 14'h456, 2'b10);
        wait_gnt(20, g, which);
        rd_req = 1'b0;
        chk("rd_gnt_cycle", g, p + 1 + T_RCD);
        chk("rd_gnt_dir", which, 2'b10);
        step(1);
        chk("rd_gnt_pulse", rd_gnt, 0);
        step(T_RP - 1);
        chk("busy_in_tpre", busy, 1);
        step(1);
        chk("busy_idle_after_rd", busy, 0);

        // Simultaneous requests held for four grants.
        do_reset();
        step(1);
        p = cyc;
        rd_addr = 32'h0ABC_DEF0;
        wr_addr = 32'hF7FF_FFFF;
        rd_req = 1'b1;
        wr_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wr_k = WrPrio || (k % 2 == 1);
            expect_act(p + 9 * k, wr_k ? wr_addr : rd_addr);
            expect_rw(p + 9 * k, wr_k, wr_k ? wr_addr : rd_addr);
        end
        for (int k = 0; k < 4; k++) begin
            wr_k = WrPrio || (k % 2 == 1);
            wait_gnt(20, g, which);
            chk("tie_order", which, wr_k ? 2'b01 : 2'b10);
            chk("tie_cycle", g, p + 9 * k + 1 + T_RCD);
        end
        rd_req = 1'b0;
        wr_req = 1'b0;
        step(T_RP + 2);

        // Refresh with no traffic.
        do_reset();
        r = cyc;
        for (int k = 0; k < 3; k++) push(r + 1 + T_REFI * (k + 1), P_REF, 3'd0, 14'd0, 2'b00);
        for (int k = 0; k < 2; k++) begin
            step_to(r + 1 + T_REFI * (k + 1));
            chk("ref_busy", busy, 1);
            for (int i = 1; i < T_RFC; i++) begin
                step(1);
                chk("trfc_busy", busy, 1);
                chk("trfc_nop", {CS_, RAS_, CAS_, WE_}, P_NOP);
            end
            step(1);
            chk("ref_done_idle", busy, 0);
        end
        step_to(r + 2 + 3 * T_REFI);

        // Request arriving on the cycle refresh becomes pending.
        do_reset();
        r = cyc;
        step_to(r + T_REFI);
        rd_addr = 32'h0000_2C05;
        rd_req = 1'b1;
        push(r + T_REFI + 1, P_REF, 3'd0, 14'd0, 2'b00);
        p = r + T_REFI + 1 + T_RFC;
        expect_act(p, rd_addr);
        expect_rw(p, 1'b0, rd_addr);
        wait_gnt(60, g, which);
        rd_req = 1'b0;
        chk("collide_gnt_cycle", g, p + 1 + T_RCD);
        step(T_RP + 2);

        // Reset asserted in TRCD; the held request is served again from ACT.
        do_reset();
        step(1);
        p = cyc;
        wr_addr = 32'h0765_4321;
        wr_req = 1'b1;
        expect_act(p, wr_addr);
        step(2);
        chk("trcd_nop", {CS_, RAS_, CAS_, WE_}, P_NOP);
        ARESETN = 1'b0;
        #1;
        chk("abort_cke", CKE, 0);
        chk("abort_pins", {CS_, RAS_, CAS_, WE_}, P_DESEL);
        chk("abort_busy_ab_a", {busy, AB, A}, 0);
        step(2);
        ARESETN = 1'b1;
        q = cyc;
        expect_act(q + 1, wr_addr);
        expect_rw(q + 1, 1'b1, wr_addr);
        wait_gnt(20, g, which);
        wr_req = 1'b0;
        chk("reserve_gnt_cycle", g, q + 2 + T_RCD);
        step(T_RP + 2);
        chk("busy_final", busy, 0);

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ddr_cmd_sched.md
# ddr_cmd_sched

Closed-page DDR2 command scheduler between the AXI4-Lite front end and the DDR2 pin driver. It arbitrates one read requester and one write requester and splits the request address into bank, row and column. It issues each access as a timed ACT → RD/WR-with-auto-precharge sequence, and it inserts periodic auto-refresh ahead of pending traffic.

## Interface
- T_RCD, 3, cycles from ACT to RD/WR (min 1)
- T_RP, 4, cycles after RD/WR until the bank is free again, covering burst and auto-precharge (min 1)
- T_RFC, 26, cycles from REF to the next command (min 1)
- T_REFI, 1560, refresh interval in cycles (min T_RFC+T_RCD+T_RP+4)
- ACLK  in  1  clock
- ARESETN  in  1  async active-low reset
- rd_req  in  1  read request, held until rd_gnt
- rd_addr  in  32  read byte address
- rd_gnt  out  1  one-cycle pulse when the RD command issues
- wr_req  in  1  write request, held until wr_gnt
- wr_addr  in  32  write byte address
- wr_gnt  out  1  one-cycle pulse when the WR command issues
- CKE  out  1  clock enable
- CS_, RAS_, CAS_, WE_  out  1 each  command pins, active-low
- AB  out  3  bank address
- A  out  14  row/column address
- busy  out  1  high in any state other than IDLE

## Operation
- Address split: col = addr[9:0], bank = addr[12:10], row = addr[26:13]. addr[31:27] is ignored.
- Commands as {CS_,RAS_,CAS_,WE_}:
  - DESEL 1111
  - NOP 0111
  - ACT 0011
  - RD 0101
  - WR 0100
  - REF 0001
- FSM states: IDLE, ACT, TRCD, RW, TPRE, REF, TRFC.
- IDLE: the priority order is refresh pending, then arbitration winner, then stay in IDLE.
  - Refresh pending → REF.
  - Otherwise the winner's address is latched and the direction is recorded → ACT.
  - With no request, the FSM stays in IDLE.
- ACT: drives ACT with AB=bank, A=row for one cycle → TRCD.
- TRCD: drives NOP for T_RCD-1 cycles → RW.
- RW: drives RD or WR for one cycle.
  - AB=bank, A={3'b0, 1'b1 (A10 auto-precharge), col}.
  - Pulses the matching gnt.
  - → TPRE.
- TPRE: drives NOP for T_RP cycles → IDLE.
- REF: drives REF for one cycle, clears refresh-pending → TRFC.
- TRFC: drives NOP for T_RFC-1 cycles → IDLE.
- Arbitration is round-robin.
  - When both requests are high in IDLE, the direction not granted last wins.
  - After reset the last-granted flag points to write, so a read wins the first tie.
- The refresh timer is free-running.
  - It counts 0..T_REFI-1 and sets refresh-pending at wrap.
  - A wrap while pending is already set is absorbed; only one refresh is owed.
  - A refresh never preempts a sequence already past IDLE.
- Requests are sampled only in IDLE. A request dropped before its gnt is a protocol violation, and the outcome is undefined.
- Wait counters are 8 bits wide except the refresh timer, which is ceil(log2(T_REFI)) bits.

## Timing
- Reset values:
  - CKE=0
  - pins DESEL
  - AB=0, A=0
  - rd_gnt=0, wr_gnt=0, busy=0
  - FSM=IDLE
  - refresh timer=0, pending=0
  - last-granted=write
- CKE rises on the first ACLK edge after ARESETN deasserts. Commands may issue from the following cycle.
- All outputs are registered. Pins change only on an ACLK rising edge.
- Request latency: with req high in IDLE and no refresh pending:
  - ACT at cycle N+1
  - RD/WR and gnt at N+1+T_RCD
  - IDLE again at N+2+T_RCD+T_RP
- Back-to-back accesses are separated by one IDLE cycle.
- Asserting ARESETN mid-sequence returns all outputs to reset values immediately. No half command remains on the pins after the next edge.
- A refresh wrap that coincides with IDLE plus a request is taken as a refresh first. The request waits T_RFC+1 cycles.

## Configuration
- Macro DDR_SCHED_WR_PRIO_EN:
  - When defined, write wins every tie and the last-granted flag is unused.
  - When undefined, ties are resolved round-robin as above.

## Structure
- Package ddr_pkg holds:
  - the command encodings
  - the FSM state enum
  - the address-field bit positions
  - default timing constants
- Sub-module ddr_refresh_timer contains the free-running counter and pending flag, with inputs ref_ack and output ref_pend.

## Test plan
- Reset release: CKE=0 and DESEL during reset. CKE=1 one cycle after release. No command before then.
- Single read, rd_addr=0x0012_3456: ACT with AB=5, A=0x091. After T_RCD cycles RD with AB=5, A=0x456. rd_gnt pulses for exactly 1 cycle. busy low T_RP+1 cycles later.
- Simultaneous rd_req and wr_req held high for 4 grants: order RD, WR, RD, WR. With DDR_SCHED_WR_PRIO_EN the order is all WR while wr_req stays high.
- Refresh with T_REFI=100 and no traffic: a REF every 100 cycles, NOP for T_RFC-1 cycles after each, busy high throughout.
- Refresh collision: rd_req rises on the cycle pending sets. REF issues first, and ACT follows at T_RFC+1 cycles.
- ARESETN asserted during TRCD: pins return to DESEL and CKE=0 at once. After release, the held request is re-served from ACT.
